rx_receiver: RTL and testbench
==============================

RX_RECEIVER -- requirements
Module: rx_receiver

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, the same divided clock that drives tx_transmitter; all state changes on rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-003 SHALL have port rx_line, input, 1 bit: serial line from the transmitter; idle level 1.
REQ-004 SHALL have port rx_packet, output, 136 bits: last received frame, MSB first on line.
REQ-005 SHALL have port rx_valid, output, 1 bit: one-cycle pulse when a complete frame is available.
REQ-006 SHALL have port crc_ok, output, 1 bit: CRC result of the frame flagged by rx_valid.
REQ-007 SHALL have port frame_err, output, 1 bit: stop bit of the last frame sampled as 0.
REQ-008 SHALL have port rx_busy, output, 1 bit: high while in DATA or STOP.

Function
REQ-009 SHALL pass rx_line through a 2-flop synchronizer (reset value 1); all sampling below uses the synchronized bit.
REQ-010 SHALL use frame format: start bit 0, then 136 data bits MSB first, then stop bit 1; one bit per clk cycle.
REQ-011 SHALL implement states IDLE, DATA and STOP.
REQ-012 In IDLE, a synchronized 0 SHALL cause a transition to DATA on the next cycle, with bit counter cleared to 0 and CRC register cleared to 8'h00.
REQ-013 In DATA, each cycle SHALL shift the synchronized bit into a 136-bit shift register LSB-side and increment an 8-bit counter.
REQ-014 After count 135 is sampled, the next state SHALL be STOP.
REQ-015 Bits 0..127 of the frame (payload) SHALL feed a serial CRC-8: polynomial x^8+x^2+x+1 (0x07), init 0x00, no reflection, no final XOR.
REQ-016 Bits 128..135 SHALL be the transmitted CRC and SHALL NOT feed the CRC register.
REQ-017 In STOP, one bit SHALL be sampled.
REQ-018 On the cycle after STOP, the block SHALL: load rx_packet from the shift register; pulse rx_valid for exactly 1 cycle; set crc_ok = (computed CRC == rx_packet[7:0]); set frame_err = NOT stop bit; return to IDLE.
REQ-019 Latency SHALL be 3 cycles from the stop bit at rx_line to rx_valid high (2 synchronizer cycles + 1).
REQ-020 rx_packet, crc_ok and frame_err SHALL hold their values until the next rx_valid.
REQ-021 A frame with frame_err=1 SHALL still be delivered (rx_valid pulses); after STOP the FSM SHALL re-enter IDLE and SHALL require a 0 to start the next frame, even if the line is still low.
REQ-022 rx_line activity during DATA/STOP SHALL NOT restart the frame; there is no timeout.
REQ-023 A start bit immediately following the stop bit (back-to-back frames) SHALL be accepted in the IDLE cycle after STOP.

Reset
REQ-024 While rst_n=0: state=IDLE, counter=0, CRC register=0, shift register=0, synchronizer=2'b11.
REQ-025 While rst_n=0: rx_packet=0, rx_valid=0, crc_ok=0, frame_err=0, rx_busy=0.
REQ-026 Reset asserted mid-frame SHALL discard the partial frame; no rx_valid SHALL follow.

Configuration
REQ-027 With macro RX_CRC_CHECK_EN defined, the CRC logic of REQ-015, REQ-016 and REQ-018 SHALL be compiled in.
REQ-028 With RX_CRC_CHECK_EN undefined, no CRC register SHALL exist; crc_ok SHALL be 1 on every rx_valid and 0 after reset; all other behaviour SHALL be unchanged.

Verification
REQ-029 Scenario: payload 128'h0, CRC byte 8'h00, stop 1 -> rx_valid pulse, rx_packet=136'h0, crc_ok=1, frame_err=0.
REQ-030 Scenario: payload 128'h1, CRC byte 8'h07 -> crc_ok=1; same frame with CRC byte 8'h06 -> crc_ok=0 (1 with RX_CRC_CHECK_EN undefined).
REQ-031 Scenario: valid frame with stop bit 0 -> rx_valid pulse, frame_err=1; line held low afterwards -> no new frame until the line returns high and falls again.
REQ-032 Scenario: two back-to-back frames, second payload 128'hFFFF_..._FFFF -> two rx_valid pulses 138 cycles apart, both with correct rx_packet.
REQ-033 Scenario: rst_n pulsed low at data bit 60 -> all outputs 0, no rx_valid; next full frame received correctly.
REQ-034 Scenario: check latency -> rx_valid high exactly 3 cycles after the stop bit is driven on rx_line.

Source files
------------

// File: rtl/rx_receiver.sv
// rx_receiver: serial frame receiver.
// Frame on the line: start bit 0, 136 data bits MSB first, stop bit 1.
// The line carries one bit per clk cycle.
// The last 8 data bits are the transmitted CRC-8 (poly 0x07) of the
// 128 payload bits.
// The CRC checker is compiled in only when RX_CRC_CHECK_EN is defined.
// Without it, crc_ok reads 1 for every delivered frame.
//
// Ports:
//   clk       - bit clock, shared with the transmitter
//   rst_n     - asynchronous active-low reset
//   rx_line   - serial input; the line idles high
//   rx_packet - last received frame (136 bits); held until the next frame
//   rx_valid  - one-cycle pulse when rx_packet/crc_ok/frame_err update
//   crc_ok    - CRC result of the frame flagged by rx_valid
//   frame_err - stop bit of the last frame was sampled as 0
//   rx_busy   - high while a frame is being shifted in (DATA or STOP)
module rx_receiver (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         rx_line,
    output logic [135:0] rx_packet,
    output logic         rx_valid,
    output logic         crc_ok,
    output logic         frame_err,
    output logic         rx_busy
);

    typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;

    localparam int unsigned FRAME_W   = 136;
    localparam int unsigned PAYLOAD_W = 128;

    logic [1:0]         sync_q;
    logic               rx_s;
    logic               prev_q;
    state_t             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [FRAME_W-1:0] shift_q, shift_d;
    logic [FRAME_W-1:0] pkt_q, pkt_d;
    logic               valid_q, valid_d;
    logic               crc_ok_q, crc_ok_d;
    logic               ferr_q, ferr_d;
`ifdef RX_CRC_CHECK_EN
    logic [7:0]         crc_q, crc_d, crc_next;
    logic               crc_fb;
`endif

    assign rx_s = sync_q[1];

`ifdef RX_CRC_CHECK_EN
    // Serial CRC-8, MSB first: feedback into the x^2+x+1 taps.
    assign crc_fb   = crc_q[7] ^ rx_s;
    assign crc_next = {crc_q[6:0], 1'b0} ^ ({8{crc_fb}} & 8'h07);
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        pkt_d    = pkt_q;
        valid_d  = 1'b0;
        crc_ok_d = crc_ok_q;
        ferr_d   = ferr_q;
`ifdef RX_CRC_CHECK_EN
        crc_d    = crc_q;
`endif
        case (state_q)
            IDLE: begin
                // Start needs a 1->0 transition.
                // A line left low after a bad stop bit must not start a frame.
                if (!rx_s && prev_q) begin
                    state_d = DATA;
                    cnt_d   = 8'd0;
`ifdef RX_CRC_CHECK_EN
                    crc_d   = 8'h00;
`endif
                end
            end
            DATA: begin
                shift_d = {shift_q[FRAME_W-2:0], rx_s};
                cnt_d   = cnt_q + 8'd1;
`ifdef RX_CRC_CHECK_EN
                // Only payload bits feed the CRC.
                // The trailing 8 bits are the CRC that was transmitted.
                if (cnt_q < 8'(PAYLOAD_W))
                    crc_d = crc_next;
`endif
                if (cnt_q == 8'(FRAME_W - 1))
                    state_d = STOP;
            end
            STOP: begin
                state_d = IDLE;
                valid_d = 1'b1;
                pkt_d   = shift_q;
                ferr_d  = ~rx_s;
`ifdef RX_CRC_CHECK_EN
                crc_ok_d = (crc_q == shift_q[7:0]);
`else
                crc_ok_d = 1'b1;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= 2'b11;
            prev_q   <= 1'b1;
            state_q  <= IDLE;
            cnt_q    <= 8'd0;
            shift_q  <= '0;
            pkt_q    <= '0;
            valid_q  <= 1'b0;
            crc_ok_q <= 1'b0;
            ferr_q   <= 1'b0;
`ifdef RX_CRC_CHECK_EN
            crc_q    <= 8'h00;
`endif
        end else begin
            sync_q   <= {sync_q[0], rx_line};
            prev_q   <= rx_s;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            pkt_q    <= pkt_d;
            valid_q  <= valid_d;
            crc_ok_q <= crc_ok_d;
            ferr_q   <= ferr_d;
`ifdef RX_CRC_CHECK_EN
            crc_q    <= crc_d;
`endif
        end
    end

    assign rx_packet = pkt_q;
    assign rx_valid  = valid_q;
    assign crc_ok    = crc_ok_q;
    assign frame_err = ferr_q;
    assign rx_busy   = (state_q == DATA) || (state_q == STOP);

endmodule

// File: tb/tb_rx_receiver.sv
// Directed bench for rx_receiver.
// It checks reset values, CRC pass/fail, stop-bit error with the line held
// low, back-to-back frames, mid-frame reset and latency.
module tb_rx_receiver;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         rx_line;
    logic [135:0] rx_packet;
    logic         rx_valid;
    logic         crc_ok;
    logic         frame_err;
    logic         rx_busy;

    rx_receiver dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_line   (rx_line),
        .rx_packet (rx_packet),
        .rx_valid  (rx_valid),
        .crc_ok    (crc_ok),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Record every rx_valid cycle seen on the falling edge.
    int           nvalid = 0;
    logic [135:0] pkts  [0:15];
    logic         crcs  [0:15];
    logic         ferrs [0:15];
    int           vcycs [0:15];
    int           stop_cyc = 0;

    always @(negedge clk) begin
        if (rx_valid) begin
            if (nvalid < 16) begin
                pkts[nvalid]  <= rx_packet;
                crcs[nvalid]  <= crc_ok;
                ferrs[nvalid] <= frame_err;
                vcycs[nvalid] <= cyc;
            end
            nvalid <= nvalid + 1;
        end
    end

    function automatic logic [7:0] crc8(input logic [127:0] p);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = 127; i >= 0; i--) begin
            fb = c[7] ^ p[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive bits 0..upto of a frame.
    // Bit 0 is the start bit, bits 1..136 are data (MSB first), bit 137 is the stop bit.
    task automatic drive_frame(input logic [135:0] pkt, input logic stop_b, input int upto);
        for (int j = 0; j <= upto; j++) begin
            @(posedge clk);
            #1;
            if (j == 0)
                rx_line = 1'b0;
            else if (j <= 136)
                rx_line = pkt[136-j];
            else begin
                rx_line  = stop_b;
                stop_cyc = cyc;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            rx_line = 1'b1;
        end
    endtask

    task automatic wait_valid(input int target, input string tag);
        for (int i = 0; i < 12 && nvalid < target; i++) begin
            @(negedge clk);
            #1;
        end
        chk(tag, 136'(nvalid >= target), 136'(1));
    endtask

    logic [135:0] fa, fb, fc, fd, fe, ff, fg, fh;
    logic         exp_c_ok;
    int           n0;

    initial begin
        fa = {128'h0, 8'h00};
        fb = {128'h1, 8'h07};
        fc = {128'h1, 8'h06};
        fd = {128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, crc8(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210)};
        fe = {128'h5, crc8(128'h5)};
        ff = {{128{1'b1}}, crc8({128{1'b1}})};
        fg = {128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555, 8'h00};
        fh = {128'hA5A5_5A5A_0F0F_F0F0_1234_5678_9ABC_DEF0, crc8(128'hA5A5_5A5A_0F0F_F0F0_1234_5678_9ABC_DEF0)};
`ifdef RX_CRC_CHECK_EN
        exp_c_ok = 1'b0;
`else
        exp_c_ok = 1'b1;
`endif

        // Reset state.
        rst_n   = 1'b0;
        rx_line = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_packet", rx_packet, 136'h0);
        chk("rst_valid", 136'(rx_valid), 136'(0));
        chk("rst_crc_ok", 136'(crc_ok), 136'(0));
        chk("rst_ferr", 136'(frame_err), 136'(0));
        chk("rst_busy", 136'(rx_busy), 136'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(5);

        // All-zero frame plus latency.
        drive_frame(fa, 1'b1, 137);
        wait_valid(1, "a_valid");
        chk("a_packet", pkts[0], fa);
        chk("a_crc_ok", 136'(crcs[0]), 136'(1));
        chk("a_ferr", 136'(ferrs[0]), 136'(0));
        chk("a_latency", 136'(vcycs[0] - stop_cyc), 136'(3));
        idle(5);
        chk("a_single_pulse", 136'(nvalid), 136'(1));

        // Good CRC, then bad CRC.
        drive_frame(fb, 1'b1, 137);
        wait_valid(2, "b_valid");
        chk("b_packet", pkts[1], fb);
        chk("b_crc_ok", 136'(crcs[1]), 136'(1));
        idle(5);
        drive_frame(fc, 1'b1, 137);
        wait_valid(3, "c_valid");
        chk("c_packet", pkts[2], fc);
        chk("c_crc_ok", 136'(crcs[2]), 136'(exp_c_ok));
        idle(10);
        @(negedge clk);
        #1;
        chk("c_hold_packet", rx_packet, fc);
        chk("c_hold_crc_ok", 136'(crc_ok), 136'(exp_c_ok));

        // Stop bit 0, then the line stays low: no new frame may start.
        drive_frame(fd, 1'b0, 137);
        wait_valid(4, "d_valid");
        chk("d_packet", pkts[3], fd);
        chk("d_ferr", 136'(ferrs[3]), 136'(1));
        chk("d_crc_ok", 136'(crcs[3]), 136'(1));
        repeat (20) @(posedge clk);
        @(negedge clk);
        #1;
        chk("d_low_no_frame", 136'(nvalid), 136'(4));
        chk("d_low_busy", 136'(rx_busy), 136'(0));
        idle(5);

        // Back-to-back frames.
        n0 = nvalid;
        drive_frame(fe, 1'b1, 137);
        drive_frame(ff, 1'b1, 137);
        wait_valid(n0 + 2, "ef_valid");
        chk("e_packet", pkts[n0], fe);
        chk("e_ferr", 136'(ferrs[n0]), 136'(0));
        chk("f_packet", pkts[n0+1], ff);
        chk("f_crc_ok", 136'(crcs[n0+1]), 136'(1));
        chk("ef_spacing", 136'(vcycs[n0+1] - vcycs[n0]), 136'(138));
        idle(5);

        // Reset at data bit 60: the partial frame must be dropped.
        n0 = nvalid;
        drive_frame(fg, 1'b1, 61);
        @(negedge clk);
        #1;
        chk("g_busy", 136'(rx_busy), 136'(1));
        rx_line = 1'b1;
        rst_n   = 1'b0;
        #2;
        chk("g_rst_packet", rx_packet, 136'h0);
        chk("g_rst_crc_ok", 136'(crc_ok), 136'(0));
        chk("g_rst_busy", 136'(rx_busy), 136'(0));
        chk("g_rst_valid", 136'(rx_valid), 136'(0));
        chk("g_rst_ferr", 136'(frame_err), 136'(0));
        idle(2);
        rst_n = 1'b1;
        idle(150);
        chk("g_no_valid", 136'(nvalid), 136'(n0));

        // A full frame after the reset.
        drive_frame(fh, 1'b1, 137);
        wait_valid(n0 + 1, "h_valid");
        chk("h_packet", pkts[n0], fh);
        chk("h_crc_ok", 136'(crcs[n0]), 136'(1));
        chk("h_latency", 136'(vcycs[n0] - stop_cyc), 136'(3));
        idle(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
